randn_multi: RTL
================

RANDN_MULTI -- requirements
Module: randn_multi

Interface
REQ-001 SHALL expose parameter NCH, default 2, number of independent noise channels (1..16).
REQ-002 SHALL expose parameter OUT_W, default 10, signed output width per channel (4..24).
REQ-003 SHALL expose parameter U_W, default 8, width of each uniform sample taken from a channel LFSR (2..16).
REQ-004 SHALL expose parameter NSUM_LOG2, default 2, log2 of the number of uniforms summed per output sample (0..6).
REQ-005 SHALL expose parameter SHIFT, default 4, arithmetic right shift applied after gain (0..15).
REQ-006 SHALL expose parameter SEED_BASE, default 32'hACE1_2468, base seed for all channels.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 set  input  1  reset, asynchronous, active-high.
REQ-009 en  input  1  advance enable; LFSRs, counter and accumulators move only when en=1.
REQ-010 gain  input  8  unsigned runtime gain, sampled at the scaling stage.
REQ-011 out  output  NCH*OUT_W  packed signed samples, channel k in bits [k*OUT_W +: OUT_W].
REQ-012 out_valid  output  1  one-cycle pulse marking a new out word on all channels.

Function
REQ-013 Each channel SHALL own a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, shifting once per en=1 cycle.
REQ-014 Channel k seed SHALL be SEED_BASE XOR (k * 32'h9E37_79B9), forced to 32'h0000_0001 when zero.
REQ-015 Uniform u_k SHALL be the top U_W bits of the pre-shift LFSR state, interpreted as two's complement.
REQ-016 A shared counter cnt (NSUM_LOG2 bits) SHALL increment on each en=1 cycle, wrapping 2^NSUM_LOG2-1 -> 0.
REQ-017 Accumulator acc_k, width U_W+NSUM_LOG2, SHALL add u_k each en=1 cycle; on the wrap cycle sum_k <= acc_k+u_k, acc_k <= 0, and internal sum_vld SHALL pulse next cycle.
REQ-018 Scaling stage: when sum_vld=1, out_k <= limit((sum_k * gain) >>> SHIFT); out_valid SHALL be registered and pulse in the same cycle out updates.
REQ-019 Latency: out_valid SHALL rise one clock after sum_vld, i.e. after the (2^NSUM_LOG2 + 1)-th en=1 edge following reset; then every 2^NSUM_LOG2 en=1 cycles.
REQ-020 en deasserted SHALL freeze LFSRs, cnt and acc_k; a pending sum_vld SHALL still complete scaling, independent of en.
REQ-021 out SHALL hold its value between out_valid pulses.
REQ-022 With NSUM_LOG2=0, every en=1 cycle SHALL produce sum_vld (output each cycle, latency 2).
REQ-023 gain SHALL be sampled only on sum_vld cycles; changes elsewhere have no effect.

Reset
REQ-024 set=1 SHALL immediately load all LFSRs with their seeds and clear cnt, acc_k, sum_k, sum_vld, out (all zeros) and out_valid (0).
REQ-025 Reset mid-accumulation SHALL discard partial sums; the post-reset output sequence SHALL be bit-identical to that after the first reset.

Configuration
REQ-026 With macro RANDN_SAT_EN defined, limit() SHALL clamp to [-(2^(OUT_W-1)-1), +(2^(OUT_W-1)-1)] (symmetric).
REQ-027 Without RANDN_SAT_EN, limit() SHALL keep the low OUT_W bits (two's complement wrap), with no clamp logic.

Verification
REQ-028 Defaults, en=1 continuously, gain=16 after reset -> first out_valid after 5th rising edge, then every 4 cycles; out matches bit-exact C model of REQ-013..018.
REQ-029 gain=0 -> out_valid pulses keep cadence, out=0 on all channels.
REQ-030 RANDN_SAT_EN defined, SHIFT=0, gain=255 -> every out in [-511,+511], at least one sample of each extreme over 1000 outputs; undefined -> values equal low 10 bits of model product.
REQ-031 en toggled 1,0,0,1 pattern -> out_valid only after every 4th en=1 cycle; sequence equals the en=1-continuous sequence.
REQ-032 set pulsed at cnt=2 -> outputs/out_valid zero immediately; subsequent sequence identical to REQ-028.
REQ-033 NCH=4, 2^16 samples -> channels pairwise differ, per-channel mean within ±2 LSB of model mean, variance within 2% of model.

Source files
------------

// File: rtl/randn_multi.sv
// Multi-channel approximate-Gaussian noise source: per-channel Galois LFSR uniforms,
// summed in groups, scaled by a runtime gain. Define RANDN_SAT_EN for symmetric output clamping.
module randn_multi #(
    parameter int          NCH       = 2,
    parameter int          OUT_W     = 10,
    parameter int          U_W       = 8,
    parameter int          NSUM_LOG2 = 2,
    parameter int          SHIFT     = 4,
    parameter logic [31:0] SEED_BASE = 32'hACE1_2468
) (
    input  logic                 clk,
    input  logic                 set,
    input  logic                 en,
    input  logic [7:0]           gain,
    output logic [NCH*OUT_W-1:0] out,
    output logic                 out_valid
);

    localparam int AW = U_W + NSUM_LOG2;              // exact width of a sum of 2^NSUM_LOG2 uniforms
    localparam int PW = AW + 9;                       // signed sum times unsigned 8-bit gain
    localparam int EW = (PW > OUT_W) ? PW : OUT_W;
    localparam int CW = (NSUM_LOG2 > 0) ? NSUM_LOG2 : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((1 << NSUM_LOG2) - 1);
    localparam logic [31:0]   POLY    = 32'h8020_0003; // x^32+x^22+x^2+x+1, right-shifting Galois form

    logic [CW-1:0] cnt;
    logic          wrap;
    logic          sum_vld;

    // With NSUM_LOG2=0 the counter sits at zero, so every enabled cycle closes a group.
    assign wrap = (cnt == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge set) begin
        if (set) begin
            cnt       <= '0;
            sum_vld   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            sum_vld   <= en & wrap;
            out_valid <= sum_vld;
            if (en) cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [31:0] SEED_RAW = SEED_BASE ^ (32'(k) * 32'h9E37_79B9);
        localparam logic [31:0] SEED     = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;

        logic [31:0]             lfsr;
        logic signed [AW-1:0]    acc;
        logic signed [AW-1:0]    sum;
        logic signed [AW-1:0]    u_ext;
        logic signed [EW-1:0]    sum_ext;
        logic signed [EW-1:0]    gain_ext;
        logic signed [OUT_W-1:0] lim;
        logic signed [OUT_W-1:0] outr;

        assign u_ext    = AW'($signed(lfsr[31 -: U_W]));
        assign sum_ext  = EW'(sum);
        assign gain_ext = EW'({1'b0, gain});

`ifdef RANDN_SAT_EN
        localparam logic signed [EW-1:0] SAT_HI = EW'((1 << (OUT_W - 1)) - 1);
        localparam logic signed [EW-1:0] SAT_LO = -SAT_HI;
        logic signed [EW-1:0] sh;

        // NOTE: every path assigns lim, so this stays purely combinational with no latch.
        always_comb begin
            sh = (sum_ext * gain_ext) >>> SHIFT;
            if (sh > SAT_HI)      lim = OUT_W'(SAT_HI);
            else if (sh < SAT_LO) lim = OUT_W'(SAT_LO);
            else                  lim = OUT_W'(sh);
        end
`else
        always_comb begin
            lim = OUT_W'((sum_ext * gain_ext) >>> SHIFT);
        end
`endif

        always_ff @(posedge clk or posedge set) begin
            if (set) begin
                lfsr <= SEED;
                acc  <= '0;
                sum  <= '0;
                outr <= '0;
            end else begin
                if (en) begin
                    lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'd0);
                    if (wrap) begin
                        sum <= acc + u_ext;
                        acc <= '0;
                    end else begin
                        acc <= acc + u_ext;
                    end
                end
                // Scaling finishes a pending group even if en has dropped.
                if (sum_vld) outr <= lim;
            end
        end

        assign out[k*OUT_W +: OUT_W] = outr;
    end

endmodule
